// File: rtl/game_pkg.sv
// Shared constants for the game I/O blocks: FSM encodings and common widths.
package game_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    HOLD = ST_HOLD,
    GAP  = ST_GAP
  } stretch_state_e;

  localparam int unsigned MISSED_W = 8;

  // Roughly 100 ms of LED on-time at a 50 MHz board clock.
  localparam int unsigned HOLD_VISIBLE = 5_000_000;

endpackage

// File: rtl/stretch_counter.sv
// Loadable down-counter shared by the HOLD and GAP phases; stops at zero.
module stretch_counter #(
  parameter int unsigned CNT_W = 26
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Load,
  input  logic [CNT_W-1:0] Load_Value,
  input  logic             Dec,
  output logic             Zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count <= '0;
    end else if (Load) begin
      count <= Load_Value;
    end else if (Dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign Zero = (count == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Turns one-shot Trigger events into HOLD_CYCLES-long Level_Out pulses followed
// by a GAP_CYCLES forced-low gap; reports completed pulses and dropped events.
module pulse_stretcher
  import game_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 3,
  parameter int unsigned RETRIGGER   = 0,
  parameter int unsigned CNT_W       = 26
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Trigger,
  output logic                Level_Out,
  output logic                Busy,
  output logic                Done,
  output logic                Missed,
  output logic [MISSED_W-1:0] Missed_Count,
  output logic [1:0]          State
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam bit               RETRIG_EN = (RETRIGGER != 0);
  localparam bit               GAP_EN    = (GAP_CYCLES > 0);

  stretch_state_e   state;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_dec;
  logic             cnt_zero;

  assign State = state;

  // Counter control decoded from the current state so the FSM sees a fresh
  // count on the same edge that it changes state.
  always_comb begin
    cnt_load  = 1'b0;
    cnt_value = HOLD_LOAD;
    cnt_dec   = 1'b0;
    case (state)
      IDLE: cnt_load = Trigger;
      HOLD: begin
        if (Trigger && RETRIG_EN) begin
          cnt_load = 1'b1;
        end else if (cnt_zero) begin
          cnt_load  = GAP_EN;
          cnt_value = GAP_LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      GAP:     cnt_dec = 1'b1;
      default: ;
    endcase
  end

  stretch_counter #(.CNT_W(CNT_W)) u_counter (
    .Clock      (Clock),
    .Reset      (Reset),
    .Load       (cnt_load),
    .Load_Value (cnt_value),
    .Dec        (cnt_dec),
    .Zero       (cnt_zero)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= IDLE;
      Level_Out    <= 1'b0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Missed       <= 1'b0;
      Missed_Count <= '0;
    end else begin
      Done   <= 1'b0;
      Missed <= 1'b0;
      case (state)
        IDLE: begin
          if (Trigger) begin
            state     <= HOLD;
            Level_Out <= 1'b1;
            Busy      <= 1'b1;
          end
        end
        HOLD: begin
          if (Trigger && !RETRIG_EN) begin
            Missed <= 1'b1;
            if (Missed_Count != '1) Missed_Count <= Missed_Count + 1'b1;
          end
          if (!(Trigger && RETRIG_EN) && cnt_zero) begin
            Level_Out <= 1'b0;
            Done      <= 1'b1;
            state     <= GAP_EN ? GAP : IDLE;
            Busy      <= GAP_EN;
          end
        end
        GAP: begin
          if (Trigger) begin
            Missed <= 1'b1;
            if (Missed_Count != '1) Missed_Count <= Missed_Count + 1'b1;
          end
          if (cnt_zero) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          Level_Out <= 1'b0;
          Busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: default build, a retrigger build and a no-gap build.
module tb_pulse_stretcher;

  logic       clk;
  logic       rst;
  logic       trig0, trig1, trig2;
  logic       lvl0, busy0, done0, miss0;
  logic       lvl1, busy1, done1, miss1;
  logic       lvl2, busy2, done2, miss2;
  logic [7:0] mc0, mc1, mc2;
  logic [1:0] st0, st1, st2;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [3:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pulse_stretcher #(.HOLD_CYCLES(4), .GAP_CYCLES(3), .RETRIGGER(0), .CNT_W(26)) dut0 (
    .Clock(clk), .Reset(rst), .Trigger(trig0), .Level_Out(lvl0), .Busy(busy0),
    .Done(done0), .Missed(miss0), .Missed_Count(mc0), .State(st0));

  pulse_stretcher #(.HOLD_CYCLES(4), .GAP_CYCLES(3), .RETRIGGER(1), .CNT_W(26)) dut1 (
    .Clock(clk), .Reset(rst), .Trigger(trig1), .Level_Out(lvl1), .Busy(busy1),
    .Done(done1), .Missed(miss1), .Missed_Count(mc1), .State(st1));

  pulse_stretcher #(.HOLD_CYCLES(4), .GAP_CYCLES(0), .RETRIGGER(0), .CNT_W(26)) dut2 (
    .Clock(clk), .Reset(rst), .Trigger(trig2), .Level_Out(lvl2), .Busy(busy2),
    .Done(done2), .Missed(miss2), .Missed_Count(mc2), .State(st2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    trig0 = 1'b0; trig1 = 1'b0; trig2 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if ({lvl0, busy0, done0, miss0, mc0, st0} !== 14'd0) begin
      $display("FAIL reset_dut0 got=%h exp=0", {lvl0, busy0, done0, miss0, mc0, st0});
    end else pass_cnt++;
    total_cnt++;
    if ({lvl2, busy2, done2, miss2, mc2, st2, lvl1, busy1, mc1} !== 24'd0) begin
      $display("FAIL reset_dut12 got=%h exp=0", {lvl2, busy2, done2, miss2, mc2, st2, lvl1, busy1, mc1});
    end else pass_cnt++;
  endtask

  task automatic test_single();
    logic [3:0] e;
    do_reset();
    trig0 = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      trig0 = 1'b0;
      exp_q.push_back({(c >= 1 && c <= 4), (c >= 1 && c <= 7), (c == 5), 1'b0});
      e = exp_q.pop_front();
      total_cnt++;
      if ({lvl0, busy0, done0, miss0} !== e) begin
        $display("FAIL single c=%0d got=%b exp=%b", c, {lvl0, busy0, done0, miss0}, e);
      end else pass_cnt++;
      if (c == 2 || c == 6 || c == 9) begin
        total_cnt++;
        if (st0 !== ((c == 2) ? 2'd1 : (c == 6) ? 2'd2 : 2'd0)) begin
          $display("FAIL single_state c=%0d got=%0d", c, st0);
        end else pass_cnt++;
      end
    end
  endtask

  task automatic test_hold_trigger();
    do_reset();
    trig0 = 1'b1; trig1 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      trig0 = (c == 2); trig1 = (c == 2);
      total_cnt++;
      if ({lvl0, done0, miss0} !== {(c <= 4), (c == 5), (c == 3)}) begin
        $display("FAIL drop c=%0d got=%b exp=%b", c, {lvl0, done0, miss0}, {(c <= 4), (c == 5), (c == 3)});
      end else pass_cnt++;
      total_cnt++;
      if ({lvl1, busy1, done1, miss1} !== {(c <= 6), (c <= 9), (c == 7), 1'b0}) begin
        $display("FAIL reload c=%0d got=%b exp=%b", c, {lvl1, busy1, done1, miss1}, {(c <= 6), (c <= 9), (c == 7), 1'b0});
      end else pass_cnt++;
    end
    total_cnt++;
    if (mc0 !== 8'd1 || mc1 !== 8'd0) begin
      $display("FAIL hold_trig_count got=%0d/%0d exp=1/0", mc0, mc1);
    end else pass_cnt++;
  endtask

  task automatic test_final_hold();
    do_reset();
    trig0 = 1'b1; trig1 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      trig0 = (c == 4); trig1 = (c == 4);
      total_cnt++;
      if ({lvl0, done0, miss0} !== {(c <= 4), (c == 5), (c == 5)}) begin
        $display("FAIL final_hold_drop c=%0d got=%b exp=%b", c, {lvl0, done0, miss0}, {(c <= 4), (c == 5), (c == 5)});
      end else pass_cnt++;
      total_cnt++;
      if ({lvl1, done1, miss1} !== {(c <= 8), (c == 9), 1'b0}) begin
        $display("FAIL final_hold_reload c=%0d got=%b exp=%b", c, {lvl1, done1, miss1}, {(c <= 8), (c == 9), 1'b0});
      end else pass_cnt++;
    end
  endtask

  task automatic test_gap_edge();
    do_reset();
    trig0 = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      trig0 = (c == 7) || (c == 8);
      total_cnt++;
      if ({lvl0, done0, miss0} !== {((c <= 4) || (c >= 9 && c <= 12)), (c == 5 || c == 13), (c == 8)}) begin
        $display("FAIL gap_edge c=%0d got=%b exp=%b", c, {lvl0, done0, miss0},
                 {((c <= 4) || (c >= 9 && c <= 12)), (c == 5 || c == 13), (c == 8)});
      end else pass_cnt++;
    end
    total_cnt++;
    if (mc0 !== 8'd1) begin
      $display("FAIL gap_edge_count got=%0d exp=1", mc0);
    end else pass_cnt++;
  endtask

  task automatic test_continuous();
    do_reset();
    trig0 = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      total_cnt++;
      if ({lvl0, miss0} !== {(((t - 1) % 8) < 4), (((t - 1) % 8) != 0)}) begin
        $display("FAIL continuous t=%0d got=%b exp=%b", t, {lvl0, miss0},
                 {(((t - 1) % 8) < 4), (((t - 1) % 8) != 0)});
      end else pass_cnt++;
    end
    total_cnt++;
    if (mc0 !== 8'd35) begin
      $display("FAIL continuous_count got=%0d exp=35", mc0);
    end else pass_cnt++;
    for (int t = 0; t < 300; t++) tick();
    total_cnt++;
    if (mc0 !== 8'd255) begin
      $display("FAIL saturate got=%0d exp=255", mc0);
    end else pass_cnt++;
    trig0 = 1'b0;
    for (int t = 0; t < 10; t++) tick();
    total_cnt++;
    if ({mc0, busy0, lvl0} !== {8'd255, 1'b0, 1'b0}) begin
      $display("FAIL saturate_hold got=%0d busy=%b lvl=%b exp=255/0/0", mc0, busy0, lvl0);
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    trig0 = 1'b1;
    tick();
    trig0 = 1'b0;
    tick();
    tick();
    rst = 1'b1; trig0 = 1'b1;
    tick();
    total_cnt++;
    if ({lvl0, busy0, done0, miss0, mc0, st0} !== 14'd0) begin
      $display("FAIL reset_mid got=%h exp=0", {lvl0, busy0, done0, miss0, mc0, st0});
    end else pass_cnt++;
    rst = 1'b0; trig0 = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      total_cnt++;
      if ({lvl0, done0} !== 2'b00) begin
        $display("FAIL reset_mid_quiet c=%0d got=%b exp=00", c, {lvl0, done0});
      end else pass_cnt++;
    end
    trig0 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      trig0 = 1'b0;
      total_cnt++;
      if ({lvl0, done0} !== {(c <= 4), (c == 5)}) begin
        $display("FAIL reset_mid_restart c=%0d got=%b exp=%b", c, {lvl0, done0}, {(c <= 4), (c == 5)});
      end else pass_cnt++;
    end
  endtask

  task automatic test_no_gap();
    do_reset();
    trig2 = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      tick();
      trig2 = (c == 5);
      total_cnt++;
      if ({lvl2, busy2, done2, miss2} !==
          {((c <= 4) || (c >= 6 && c <= 9)), ((c <= 4) || (c >= 6 && c <= 9)), (c == 5 || c == 10), 1'b0}) begin
        $display("FAIL no_gap c=%0d got=%b exp=%b", c, {lvl2, busy2, done2, miss2},
                 {((c <= 4) || (c >= 6 && c <= 9)), ((c <= 4) || (c >= 6 && c <= 9)), (c == 5 || c == 10), 1'b0});
      end else pass_cnt++;
    end
    total_cnt++;
    if (mc2 !== 8'd0) begin
      $display("FAIL no_gap_count got=%0d exp=0", mc2);
    end else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    trig0 = 1'b0; trig1 = 1'b0; trig2 = 1'b0;
    test_reset();
    test_single();
    test_hold_trigger();
    test_final_hold();
    test_gap_edge();
    test_continuous();
    test_reset_mid();
    test_no_gap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
Output-side counterpart to the switch debouncer. It takes single-cycle one-shot events, such as a debounced press or a game "catch" event, and turns them into a held, minimum-duration level for LEDs, buzzers or off-board outputs. After each held pulse it enforces a mandatory low gap. It reports completed pulses and counts events it had to drop.

Parameters:
HOLD_CYCLES, 4, number of cycles Level_Out stays high per accepted event; must be >= 1
GAP_CYCLES, 3, number of forced-low cycles after each pulse; 0 means no gap
RETRIGGER, 0, 1 = a Trigger during HOLD reloads the hold counter; 0 = the Trigger is dropped
CNT_W, 26, width of the internal down-counter; must hold max(HOLD_CYCLES, GAP_CYCLES) - 1

Ports:
Clock  input  1  single system clock; all logic on its rising edge
Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clock
Trigger  input  1  one-shot event request; each high cycle is one event
Level_Out  output  1  stretched pulse (registered)
Busy  output  1  high while in HOLD or GAP (registered)
Done  output  1  one-cycle pulse in the cycle after HOLD ends (registered)
Missed  output  1  one-cycle pulse in the cycle after a Trigger was dropped (registered)
Missed_Count  output  8  saturating count of dropped Triggers

Behaviour:
- Reset:
  - state = IDLE, counter = 0.
  - Level_Out, Busy, Done, Missed = 0; Missed_Count = 0.
  - Reset overrides every other input in the same cycle, including mid-HOLD or mid-GAP.
- States: IDLE, HOLD, GAP. All outputs are registered.
- IDLE:
  - Trigger=1 at edge k -> state HOLD, counter = HOLD_CYCLES-1.
  - Level_Out=1 and Busy=1 are visible from cycle k+1.
  - Trigger=0 -> stay in IDLE.
- HOLD:
  - counter != 0 -> decrement.
  - counter == 0 -> leave HOLD: to GAP with counter = GAP_CYCLES-1 if GAP_CYCLES > 0, else to IDLE.
  - Level_Out drops and Done=1 on the same edge that leaves HOLD.
  - Level_Out is therefore high exactly HOLD_CYCLES cycles per non-retriggered event.
- Trigger in HOLD:
  - RETRIGGER=1 -> counter reloads to HOLD_CYCLES-1; Level_Out stays high with no glitch; not counted as missed.
  - RETRIGGER=0 -> Trigger ignored; Missed pulses next cycle; Missed_Count increments.
  - Trigger in the final HOLD cycle (counter == 0):
    - RETRIGGER=1 -> reload wins, stay in HOLD, no Done.
    - RETRIGGER=0 -> exit as normal, plus Missed.
- GAP:
  - Level_Out=0, Busy=1, counter decrements.
  - counter == 0 -> IDLE, Busy drops on that edge.
  - Any Trigger in GAP is dropped (Missed pulse, Missed_Count increments).
  - Trigger in the final GAP cycle is also dropped; a Trigger in the first IDLE cycle is accepted.
- GAP_CYCLES=0: HOLD exits to IDLE. A Trigger in the cycle right after Done is accepted, giving a minimum 1-cycle low between pulses.
- Missed_Count saturates at 255 and holds; it is cleared only by Reset.
- Done and Missed are never high for more than one consecutive cycle each per event, and they may coincide.
- Illegal state encoding -> IDLE on the next edge, with all outputs as in IDLE.

Decomposition:
- Shared package (game_pkg):
  - state encodings IDLE/HOLD/GAP as localparams
  - MISSED_W = 8
  - reusable timing constants, e.g. HOLD_VISIBLE for human-visible LED time at the board clock.
- One sub-module, stretch_counter:
  - CNT_W-bit loadable down-counter.
  - Inputs: Clock, Reset, Load, Load_Value, Dec.
  - Output: Zero flag.
  - Instantiated once for both the HOLD and GAP phases.
- The FSM and output registers stay in pulse_stretcher.

Test Plan:
- Reset, then a single Trigger at cycle 10 (HOLD=4, GAP=3) -> Level_Out high in cycles 11-14, Done=1 in cycle 15, Busy high 11-17, IDLE by 18.
- Trigger during HOLD at cycle 12, RETRIGGER=0 -> Missed=1 in cycle 13, Missed_Count=1, Level_Out still ends after cycle 14.
- Same stimulus with RETRIGGER=1 -> Level_Out high 11-16, Done at 17, Missed never asserts.
- Trigger held high continuously for 40 cycles (RETRIGGER=0) -> pulses repeat with a 4-high/3-low pattern plus 1 cycle; Missed_Count equals dropped cycles; then force 300 drops -> Missed_Count saturates at 255.
- Reset asserted in cycle 13 mid-HOLD with Trigger=1 -> cycle 14 all outputs 0, state IDLE, no Done; next Trigger restarts a full 4-cycle pulse.
- GAP_CYCLES=0: Triggers at cycles 10 and 15 -> two pulses (11-14 and 16-19), Done at 15 and 20, no Missed.
